// File: rtl/r2rv_pkg.sv
// Shared core-wide widths and the result-bus record snooped by reservation stations.
package r2rv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  data;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin selector: searches from the pointer upward, wrapping, and
// moves the pointer just past the winner. Reusable for issue selection.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             any_grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        grant_idx = ptr_reg;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single conditional subtract is a full modulo
            sum = {1'b0, ptr_reg} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (enable && !any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (any_grant) begin
            ptr_next = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one round-robin winner per cycle, registered onto the
// broadcast bus and the register-file write port one cycle after the grant.
module cdb_arbiter
    import r2rv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int XLEN  = r2rv_pkg::XLEN,
    parameter int REG_W = r2rv_pkg::REG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*REG_W-1:0] req_dest,
    input  logic [N_REQ*XLEN-1:0]  req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   cdb_valid,
    output logic [REG_W-1:0]       cdb_dest,
    output logic [XLEN-1:0]        cdb_data,
    output logic [REG_W-1:0]       wa3,
    output logic [XLEN-1:0]        wd3
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [REG_W-1:0] req_dest_arr [N_REQ];
    logic [XLEN-1:0]  req_data_arr [N_REQ];
    logic             any_grant;
    logic [PTR_W-1:0] grant_idx;
    logic             cdb_valid_reg;
    logic [REG_W-1:0] cdb_dest_reg;
    logic [XLEN-1:0]  cdb_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_dest_arr[gi] = req_dest[gi*REG_W +: REG_W];
            assign req_data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Grants are suppressed both by flush and while reset is held low.
    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .enable    (reset & ~flush),
        .req       (req_valid),
        .grant     (req_ready),
        .any_grant (any_grant),
        .grant_idx (grant_idx)
    );

    // Idle cycles keep the last tag/data so only the valid bit toggles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_reg <= 1'b0;
            cdb_dest_reg  <= '0;
            cdb_data_reg  <= '0;
        end else begin
            cdb_valid_reg <= any_grant;
            if (any_grant) begin
                cdb_dest_reg <= req_dest_arr[grant_idx];
                cdb_data_reg <= req_data_arr[grant_idx];
            end
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_dest  = cdb_dest_reg;
    assign cdb_data  = cdb_data_reg;
    assign wa3       = cdb_valid_reg ? cdb_dest_reg : '0;
    assign wd3       = cdb_data_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed checks of cdb_arbiter against a round-robin reference model.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [19:0]  req_dest = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_dest;
    logic [31:0]  cdb_data;
    logic [4:0]   wa3;
    logic [31:0]  wd3;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [31:0] m_data = '0;
    int          exp_g = -1;
    logic [3:0]  exp_ready = '0;

    cdb_arbiter #(.N_REQ(4), .XLEN(32), .REG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_dest  (cdb_dest),
        .cdb_data  (cdb_data),
        .wa3       (wa3),
        .wd3       (wd3)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int pick(input logic [3:0] v, input logic fl, input int p);
        if (fl) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] x);
        req_dest[i*5 +: 5]   = d;
        req_data[i*32 +: 32] = x;
    endtask

    task automatic drive(input logic [3:0] v, input logic fl);
        req_valid = v;
        flush     = fl;
        exp_g     = pick(v, fl, m_ptr);
        exp_ready = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_dest = '0; m_data = '0; exp_g = -1;
    endtask

    // Advance through one rising edge, update the model, settle 1 time unit after.
    task automatic tick();
        @(posedge clk);
        if (exp_g >= 0) begin
            m_valid = 1'b1;
            m_dest  = req_dest[exp_g*5 +: 5];
            m_data  = req_data[exp_g*32 +: 32];
            m_ptr   = (exp_g + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h1000 + i);
        req_valid = 4'b1111;
        #2;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_cmp++; if ({cdb_valid, cdb_dest, cdb_data, wa3, wd3} !== '0) begin n_bad++;
            $display("FAIL reset_outputs: got v=%b dest=%h data=%h wa3=%h wd3=%h want all 0", cdb_valid, cdb_dest, cdb_data, wa3, wd3); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(4'b1111, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b1 || wa3 !== 5'd1 || wd3 !== 32'h1000) begin n_bad++;
            $display("FAIL reset_first_bcast: got v=%b wa3=%h wd3=%h want 1/01/00001000", cdb_valid, wa3, wd3); end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(2, 5'd7, 32'hDEADBEEF);
        drive(4'b0100, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL single_bcast: got v=%b wa3=%h wd3=%h want 1/07/deadbeef", cdb_valid, wa3, wd3); end
        @(negedge clk);
        drive(4'b0000, 1'b0);
        tick();
        n_cmp++; if (cdb_valid !== 1'b0 || wa3 !== 5'd0 || wd3 !== 32'hDEADBEEF || cdb_dest !== 5'd7) begin n_bad++;
            $display("FAIL single_idle: got v=%b wa3=%h wd3=%h dest=%h want 0/00/deadbeef/07", cdb_valid, wa3, wd3, cdb_dest); end
    endtask

    task automatic test_wrap();
        // pointer sits at 3 after the single-requester grant to 2
        @(negedge clk);
        set_req(0, 5'd10, 32'hA0); set_req(1, 5'd11, 32'hA1);
        drive(4'b0011, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_first: got %b want 0001", req_ready); end
        tick();
        @(negedge clk);
        drive(4'b0011, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_second: got %b want 0010", req_ready); end
        tick();
        n_cmp++; if (wa3 !== 5'd11 || cdb_data !== 32'hA1) begin n_bad++; $display("FAIL wrap_bcast: got wa3=%h data=%h want 0b/000000a1", wa3, cdb_data); end
    endtask

    task automatic test_contention();
        int cnt [N];
        for (int i = 0; i < N; i++) cnt[i] = 0;
        @(negedge clk);
        drive(4'b1000, 1'b0);
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) set_req(i, 5'(16 + i), 32'hC000 + 32'(c * 4 + i));
            drive(4'b1111, 1'b0);
            #1;
            n_cmp++; if (req_ready !== 4'(1 << (c % 4))) begin n_bad++;
                $display("FAIL contention_order[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
            tick();
            n_cmp++; if (wa3 !== 5'(16 + c % 4) || wd3 !== 32'hC000 + 32'(c * 4 + c % 4)) begin n_bad++;
                $display("FAIL contention_bcast[%0d]: got wa3=%h wd3=%h", c, wa3, wd3); end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (cnt[i] != 2) begin n_bad++; $display("FAIL contention_count[%0d]: got %0d want 2", i, cnt[i]); end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        set_req(1, 5'd21, 32'hF1);
        drive(4'b0010, 1'b0);
        tick();
        @(negedge clk);
        drive(4'b1111, 1'b1);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
        n_cmp++; if (cdb_valid !== 1'b1 || wa3 !== 5'd21) begin n_bad++; $display("FAIL flush_prev_bcast: got v=%b wa3=%h want 1/15", cdb_valid, wa3); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b0 || wa3 !== 5'd0 || cdb_dest !== 5'd21) begin n_bad++;
            $display("FAIL flush_idle: got v=%b wa3=%h dest=%h want 0/00/15", cdb_valid, wa3, cdb_dest); end
        @(negedge clk);
        drive(4'b1111, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL flush_ptr_hold: got %b want 0100", req_ready); end
        tick();
    endtask

    task automatic test_x0();
        @(negedge clk);
        set_req(3, 5'd0, 32'd5);
        drive(4'b1000, 1'b0);
        tick();
        n_cmp++; if (cdb_valid !== 1'b1 || cdb_dest !== 5'd0 || wa3 !== 5'd0 || cdb_data !== 32'd5) begin n_bad++;
            $display("FAIL x0_bcast: got v=%b dest=%h wa3=%h data=%h want 1/00/00/5", cdb_valid, cdb_dest, wa3, cdb_data); end
        @(negedge clk);
        drive(4'b1111, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL x0_ptr_advance: got %b want 0001", req_ready); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) set_req(i, 5'($urandom), $urandom);
            drive(4'($urandom), ($urandom_range(0, 7) == 0));
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
            tick();
            n_cmp++; if (cdb_valid !== m_valid || wa3 !== (m_valid ? m_dest : 5'd0) || cdb_dest !== m_dest
                         || cdb_data !== m_data || wd3 !== m_data) begin n_bad++;
                $display("FAIL rand_bcast[%0d]: got v=%b dest=%h data=%h wa3=%h wd3=%h want v=%b dest=%h data=%h",
                         c, cdb_valid, cdb_dest, cdb_data, wa3, wd3, m_valid, m_dest, m_data); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 5'(24 + i), 32'hB000 + i);
        drive(4'b1111, 1'b0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if ({cdb_valid, cdb_dest, cdb_data, wa3, wd3} !== '0 || req_ready !== 4'b0000) begin n_bad++;
            $display("FAIL midreset_clear: got v=%b dest=%h data=%h wa3=%h ready=%b want all 0", cdb_valid, cdb_dest, cdb_data, wa3, req_ready); end
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_hold: got v=%b want 0", cdb_valid); end
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midreset_first: got %b want 0001", req_ready); end
        tick();
        n_cmp++; if (cdb_valid !== 1'b1 || wa3 !== 5'd24) begin n_bad++; $display("FAIL midreset_bcast: got v=%b wa3=%h want 1/18", cdb_valid, wa3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_flush();
        test_x0();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-bus (common data bus) arbiter for the out-of-order core. Functional units (ALU, load/store, branch, …) finish results tagged with a 5-bit register destination and compete for the single register-file write port (`wa3`/`wd3`) and the broadcast bus that waiting operands snoop. The block grants one requester per cycle with a round-robin policy, registers the winner, and drives the write port and broadcast one cycle later.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting functional units (2..8).
- `XLEN`, 32: data width.
- `REG_W`, 5: destination tag width (architectural register index).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `flush` in 1: pipeline flush (branch mispredict); blocks grants this cycle.
- `req_valid` in N_REQ: requester i holds a result.
- `req_dest` in N_REQ×REG_W: destination register of requester i.
- `req_data` in N_REQ×XLEN: result value of requester i.
- `req_ready` out N_REQ: one-hot-or-zero grant; the result transfers when `req_valid[i] && req_ready[i]`.
- `cdb_valid` out 1: broadcast valid.
- `cdb_dest` out REG_W: broadcast tag.
- `cdb_data` out XLEN: broadcast value.
- `wa3` out REG_W: register-file write address (0 when idle).
- `wd3` out XLEN: register-file write data.

## Operation
- Round-robin pointer `ptr` (0..N_REQ-1). Search order: ptr, ptr+1, …, wrapping modulo N_REQ. The first valid requester wins.
- `req_ready` is combinational from `req_valid`, `ptr` and `flush`. Requesters must not make `req_valid` depend on `req_ready`.
- `req_ready` = 0 for all requesters when `flush` = 1 or no requester is valid. At most one bit is set.
- On a grant to i: `ptr` ← (i+1) mod N_REQ. With no grant, `ptr` holds.
- Output register, loaded every cycle:
  - Grant: `cdb_valid`=1, `cdb_dest`=`req_dest[i]`, `cdb_data`=`req_data[i]`, `wa3`=`req_dest[i]`, `wd3`=`req_data[i]`.
  - No grant: `cdb_valid`=0, `wa3`=0, and `cdb_dest`/`cdb_data`/`wd3` hold their previous values.
- `wa3` is forced to 0 whenever `cdb_valid`=0. Because x0 writes are discarded, an idle cycle never modifies the register file.
- A dest=0 result is granted and broadcast normally (`cdb_valid`=1, `wa3`=0). It consumes a slot and advances `ptr`.
- Fairness: a continuously valid requester is granted within N_REQ cycles of its first valid cycle, provided `flush` stays low.
- `flush` does not cancel a result already in the output register; that result is still broadcast the cycle after its grant.
- Reset (asynchronous, any time, including mid-stream):
  - `ptr`=0.
  - `cdb_valid`=0, `cdb_dest`=0, `cdb_data`=0, `wa3`=0, `wd3`=0.
  - Any in-flight result is dropped.
  - `req_ready` is all-zero while reset is asserted.

## Timing
- Grant in cycle t, combinational on the inputs of t.
- The registered result appears on `cdb_*` and `wa3`/`wd3` in cycle t+1. Latency is 1 cycle.
- Throughput: 1 result per cycle.
- The first grant is possible in the first cycle after reset deasserts. Reset release is synchronized externally.
- No combinational path from the inputs to `cdb_*`, `wa3` or `wd3`.

## Structure
- Shared package `r2rv_pkg`: `XLEN`, `REG_W` and a `cdb_t` struct {valid, dest, data}. This struct is reused by reservation stations snooping the bus.
- One sub-module, `rr_arbiter`: parameterized N-way round-robin grant with pointer input/update. It is purely combinational plus the pointer flop and is reusable for issue selection.
- The top level holds the request mux, the output register and the `wa3` zero-forcing.

## Test plan
- **Reset:** drive reset=0 mid-broadcast with `req_valid`=4'b1111 → all outputs 0 and `req_ready`=0 immediately. After release, the first grant goes to requester 0.
- **Single requester:** `req_valid`=4'b0100, dest=7, data=0xDEADBEEF at cycle t → `req_ready`=4'b0100 at t; `cdb_valid`=1, `wa3`=7, `wd3`=0xDEADBEEF at t+1; `wa3`=0 at t+2.
- **Full contention:** `req_valid`=4'b1111 held for 8 cycles → grants in order 0,1,2,3,0,1,2,3. Each requester is granted exactly twice.
- **Wrap-around skip:** `ptr`=3 with `req_valid`=4'b0011 → grant to 0, then `ptr`=1, then grant to 1.
- **Flush:**
  - `flush`=1 with requests pending → `req_ready`=0, next cycle `cdb_valid`=0, `ptr` unchanged.
  - A grant in the preceding cycle is still broadcast.
- **x0 result:** dest=0, data=5 granted → `cdb_valid`=1, `cdb_dest`=0, `wa3`=0, and `ptr` advances.
